tea_arbiter: RTL and testbench

TEA_ARBITER -- requirements
Module: tea_arbiter

---
 rtl/tea_arbiter.sv | 137 +++++++++++++
 tb/tb_tea_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tea_arbiter.sv
// rtl/tea_arbiter.sv - round-robin two-requester front end for a TEA cipher core
// Grants one requester, feeds the cipher, then holds the result for the grant owner.
module tea_arbiter #(
    parameter int WORD_SIZE = 16,
    parameter int TIMEOUT   = 1023
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req0_valid,
    input  logic                   req1_valid,
    output logic                   req0_ready,
    output logic                   req1_ready,
    input  logic [2*WORD_SIZE-1:0] req0_data,
    input  logic [2*WORD_SIZE-1:0] req1_data,
    input  logic [4*WORD_SIZE-1:0] req0_key,
    input  logic [4*WORD_SIZE-1:0] req1_key,
    output logic                   rsp0_valid,
    output logic                   rsp1_valid,
    input  logic                   rsp0_ready,
    input  logic                   rsp1_ready,
    output logic [2*WORD_SIZE-1:0] rsp_data,
    output logic                   rsp_err,
    output logic                   oStart,
    output logic [WORD_SIZE-1:0]   oV0,
    output logic [WORD_SIZE-1:0]   oV1,
    output logic [WORD_SIZE-1:0]   oK0,
    output logic [WORD_SIZE-1:0]   oK1,
    output logic [WORD_SIZE-1:0]   oK2,
    output logic [WORD_SIZE-1:0]   oK3,
    input  logic [WORD_SIZE-1:0]   iC0,
    input  logic [WORD_SIZE-1:0]   iC1,
    input  logic                   iDone
);
    localparam int W = WORD_SIZE;
    localparam logic [9:0] CNT_LAST = 10'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_RESP} state_t;

    state_t         r_state;
    state_t         w_next;
    logic           r_owner;
    logic           r_last;
    logic [9:0]     r_cnt;
    logic [2*W-1:0] r_v;
    logic [4*W-1:0] r_k;
    logic [2*W-1:0] r_rsp_data;
    logic           r_rsp_err;

    logic w_idle;
    logic w_gnt0;
    logic w_gnt1;
    logic w_ack;
    logic w_timeout;

    // r_last = 1 means requester 1 was served last, so requester 0 wins a tie
    assign w_idle    = (r_state == S_IDLE);
    assign w_gnt0    = w_idle && req0_valid && (!req1_valid || r_last);
    assign w_gnt1    = w_idle && req1_valid && (!req0_valid || !r_last);
    assign w_ack     = r_owner ? rsp1_ready : rsp0_ready;
    assign w_timeout = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_gnt0 || w_gnt1) w_next = S_LOAD;
            S_LOAD:  w_next = S_RUN;
            S_RUN:   if (iDone || w_timeout) w_next = S_RESP;
            S_RESP:  if (w_ack) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Grants are gated by rst_n so ready stays low while reset is held
    always_comb begin
        req0_ready = w_gnt0 && rst_n;
        req1_ready = w_gnt1 && rst_n;
        rsp0_valid = (r_state == S_RESP) && !r_owner;
        rsp1_valid = (r_state == S_RESP) && r_owner;
        oStart     = (r_state == S_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner    <= 1'b0;
            r_last     <= 1'b1;
            r_cnt      <= '0;
            r_v        <= '0;
            r_k        <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_owner <= w_gnt1;
                        r_v     <= w_gnt1 ? req1_data : req0_data;
                        r_k     <= w_gnt1 ? req1_key : req0_key;
                    end
                end
                S_LOAD: r_cnt <= '0;
                S_RUN: begin
                    r_cnt <= r_cnt + 10'd1;
                    // done takes priority over a coincident timeout
                    if (iDone) begin
                        r_rsp_data <= {iC1, iC0};
                        r_rsp_err  <= 1'b0;
                    end else if (w_timeout) begin
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (w_ack) r_last <= r_owner;
                end
                default: ;
            endcase
        end
    end

    assign rsp_data = r_rsp_data;
    assign rsp_err  = r_rsp_err;
    assign oV0      = r_v[W-1:0];
    assign oV1      = r_v[2*W-1:W];
    assign oK0      = r_k[W-1:0];
    assign oK1      = r_k[2*W-1:W];
    assign oK2      = r_k[3*W-1:2*W];
    assign oK3      = r_k[4*W-1:3*W];

endmodule

// File: tb/tb_tea_arbiter.sv
// tb/tb_tea_arbiter.sv - scoreboard bench for tea_arbiter (default and TIMEOUT=8 instances)
module tb_tea_arbiter;
    logic        clk;
    logic        rst_n;

    logic        req0_valid, req1_valid, rsp0_ready, rsp1_ready, iDone;
    logic [31:0] req0_data, req1_data;
    logic [63:0] req0_key, req1_key;
    logic [15:0] iC0, iC1;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err, oStart;
    logic [31:0] rsp_data;
    logic [15:0] oV0, oV1, oK0, oK1, oK2, oK3;

    logic        t_req0_valid, t_rsp0_ready, t_done;
    logic [15:0] t_c0, t_c1;
    logic        t_req0_ready, t_req1_ready, t_rsp0_valid, t_rsp1_valid, t_rsp_err, t_oStart;
    logic [31:0] t_rsp_data;
    logic [15:0] t_oV0, t_oV1, t_oK0, t_oK1, t_oK2, t_oK3;

    localparam logic [31:0] T_DATA = 32'h1234_5678;
    localparam logic [63:0] T_KEY  = 64'h9ABC_DEF0_0F1E_2D3C;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [33:0] sb_q[$];
    logic [33:0] t_q[$];
    logic [33:0] m_exp;
    logic [33:0] t_exp;

    tea_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_data(req0_data), .req1_data(req1_data),
        .req0_key(req0_key), .req1_key(req1_key),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .oStart(oStart),
        .oV0(oV0), .oV1(oV1), .oK0(oK0), .oK1(oK1), .oK2(oK2), .oK3(oK3),
        .iC0(iC0), .iC1(iC1), .iDone(iDone)
    );

    tea_arbiter #(.WORD_SIZE(16), .TIMEOUT(8)) dut_t8 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(t_req0_valid), .req1_valid(1'b0),
        .req0_ready(t_req0_ready), .req1_ready(t_req1_ready),
        .req0_data(T_DATA), .req1_data(32'h0),
        .req0_key(T_KEY), .req1_key(64'h0),
        .rsp0_valid(t_rsp0_valid), .rsp1_valid(t_rsp1_valid),
        .rsp0_ready(t_rsp0_ready), .rsp1_ready(1'b0),
        .rsp_data(t_rsp_data), .rsp_err(t_rsp_err), .oStart(t_oStart),
        .oV0(t_oV0), .oV1(t_oV1), .oK0(t_oK0), .oK1(t_oK1), .oK2(t_oK2), .oK3(t_oK3),
        .iC0(t_c0), .iC1(t_c1), .iDone(t_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready))) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected: got response %h expected none", rsp_data);
            end else begin
                m_exp = sb_q.pop_front();
                chk1("rsp_owner", rsp1_valid, m_exp[33]);
                chk1("rsp_err", rsp_err, m_exp[32]);
                chkw("rsp_data", 64'(rsp_data), 64'(m_exp[31:0]));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && t_rsp0_valid && t_rsp0_ready) begin
            if (t_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL t8_unexpected: got response %h expected none", t_rsp_data);
            end else begin
                t_exp = t_q.pop_front();
                chk1("t8_rsp_err", t_rsp_err, t_exp[32]);
                chkw("t8_rsp_data", 64'(t_rsp_data), 64'(t_exp[31:0]));
            end
        end
    end

    // Caller applies valids/data at posedge+1 with the main DUT in IDLE; returns at posedge+1 in IDLE
    task automatic txn(input logic who, input logic [31:0] v, input logic [63:0] k,
                       input int done_at, input logic [31:0] c, input bit keep, input int hold);
        @(negedge clk);
        chk1("grant_req0", req0_ready, !who);
        chk1("grant_req1", req1_ready, who);
        @(posedge clk); #1;
        if (!keep) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
        @(negedge clk);
        chk1("load_ostart", oStart, 1'b0);
        chkw("load_ready", 64'({req0_ready, req1_ready}), 64'h0);
        chkw("load_v", 64'({oV1, oV0}), 64'(v));
        chkw("load_k", {oK3, oK2, oK1, oK0}, k);
        @(posedge clk);
        @(negedge clk);
        chk1("run_ostart", oStart, 1'b1);
        repeat (done_at) @(posedge clk);
        #1;
        iDone = 1'b1;
        iC0   = c[15:0];
        iC1   = c[31:16];
        sb_q.push_back({who, 1'b0, c});
        @(posedge clk); #1;
        iDone = 1'b0;
        if (hold > 0) begin
            if (who) begin req0_valid = 1'b1; rsp0_ready = 1'b1; end
            else     begin req1_valid = 1'b1; rsp1_ready = 1'b1; end
        end
        @(negedge clk);
        chk1("resp_owner_valid", who ? rsp1_valid : rsp0_valid, 1'b1);
        chk1("resp_other_valid", who ? rsp0_valid : rsp1_valid, 1'b0);
        chk1("resp_ostart", oStart, 1'b0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk1("hold_valid", who ? rsp1_valid : rsp0_valid, 1'b1);
            chkw("hold_data", 64'(rsp_data), 64'(c));
            chk1("hold_ostart", oStart, 1'b0);
            chkw("hold_ready", 64'({req0_ready, req1_ready}), 64'h0);
            chkw("hold_v", 64'({oV1, oV0}), 64'(v));
        end
        @(posedge clk); #1;
        if (who) rsp1_ready = 1'b1;
        else     rsp0_ready = 1'b1;
        @(posedge clk); #1;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        iDone = 1'b0; iC0 = '0; iC1 = '0;
        req0_data = 32'hAAAA_0001; req0_key = 64'h0001_0002_0003_0004;
        req1_data = 32'hBBBB_0002; req1_key = 64'h1111_2222_3333_4444;
        t_req0_valid = 1'b0; t_rsp0_ready = 1'b0; t_done = 1'b0; t_c0 = '0; t_c1 = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chkw("rst_ready", 64'({req0_ready, req1_ready}), 64'h0);
        chkw("rst_rsp_valid", 64'({rsp0_valid, rsp1_valid}), 64'h0);
        chk1("rst_ostart", oStart, 1'b0);
        chkw("rst_rsp", 64'({rsp_err, rsp_data}), 64'h0);
        chkw("rst_ops", {oV1, oV0, oK3, oK2}, 64'h0);
        chk1("rst_t8_ostart", t_oStart, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // contention: 0, then 1, then 0 again
        txn(1'b0, 32'hAAAA_0001, 64'h0001_0002_0003_0004, 2, 32'h1000_0001, 1'b1, 0);
        txn(1'b1, 32'hBBBB_0002, 64'h1111_2222_3333_4444, 2, 32'h2000_0002, 1'b1, 0);
        txn(1'b0, 32'hAAAA_0001, 64'h0001_0002_0003_0004, 2, 32'h3000_0003, 1'b0, 0);

        // single request, done at RUN cycle 390
        req0_valid = 1'b1; req0_data = 32'h0001_0002; req0_key = 64'h0003_0004_0005_0006;
        txn(1'b0, 32'h0001_0002, 64'h0003_0004_0005_0006, 390, 32'hCAFE_BEEF, 1'b0, 0);

        // backpressure for 20 cycles while req1 waits, then req1 is served
        req0_valid = 1'b1; req0_data = 32'h5555_6666; req0_key = 64'h7777_8888_9999_AAAA;
        req1_data = 32'hDDDD_EEEE; req1_key = 64'h0102_0304_0506_0708;
        txn(1'b0, 32'h5555_6666, 64'h7777_8888_9999_AAAA, 3, 32'h4444_0004, 1'b0, 20);
        txn(1'b1, 32'hDDDD_EEEE, 64'h0102_0304_0506_0708, 4, 32'h5555_0005, 1'b0, 0);

        // reset at RUN cycle 50
        req0_valid = 1'b1; req0_data = 32'hFEED_F00D; req0_key = 64'h0BAD_C0DE_0BAD_C0DE;
        @(negedge clk);
        chk1("mr_grant", req0_ready, 1'b1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk);
        repeat (50) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk1("mr_ostart", oStart, 1'b0);
        chkw("mr_rsp", 64'({rsp0_valid, rsp1_valid, rsp_err, rsp_data}), 64'h0);
        chkw("mr_ops_v", 64'({oV1, oV0}), 64'h0);
        chkw("mr_ops_k", {oK3, oK2, oK1, oK0}, 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        req1_valid = 1'b1; req1_data = 32'h0A0B_0C0D; req1_key = 64'h1020_3040_5060_7080;
        txn(1'b1, 32'h0A0B_0C0D, 64'h1020_3040_5060_7080, 5, 32'h6666_0006, 1'b0, 0);

        // TIMEOUT=8: no done -> eight RUN cycles then error
        t_req0_valid = 1'b1;
        @(negedge clk);
        chk1("t8_grant", t_req0_ready, 1'b1);
        chk1("t8_grant1", t_req1_ready, 1'b0);
        @(posedge clk); #1;
        t_req0_valid = 1'b0;
        t_q.push_back({1'b0, 1'b1, 32'h0});
        @(negedge clk);
        chk1("t8_load_ostart", t_oStart, 1'b0);
        chkw("t8_load_ops", {t_oV1, t_oV0, t_oK1, t_oK0}, {T_DATA, T_KEY[31:0]});
        chkw("t8_load_k", 64'({t_oK3, t_oK2}), 64'(T_KEY[63:32]));
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk1("t8_run_ostart", t_oStart, 1'b1);
            @(posedge clk);
        end
        @(negedge clk);
        chk1("t8_to_ostart", t_oStart, 1'b0);
        chk1("t8_to_valid", t_rsp0_valid, 1'b1);
        chk1("t8_to_valid1", t_rsp1_valid, 1'b0);
        chk1("t8_to_err", t_rsp_err, 1'b1);
        @(posedge clk); #1;
        t_rsp0_ready = 1'b1;
        @(posedge clk); #1;
        t_rsp0_ready = 1'b0;

        // TIMEOUT=8: done on the last counter value wins
        t_req0_valid = 1'b1;
        @(negedge clk);
        chk1("t8c_grant", t_req0_ready, 1'b1);
        @(posedge clk); #1;
        t_req0_valid = 1'b0;
        @(posedge clk);
        repeat (7) @(posedge clk);
        #1;
        t_done = 1'b1; t_c0 = 16'h0BB0; t_c1 = 16'hA11A;
        t_q.push_back({1'b0, 1'b0, 32'hA11A_0BB0});
        @(posedge clk); #1;
        t_done = 1'b0;
        @(negedge clk);
        chk1("t8c_valid", t_rsp0_valid, 1'b1);
        chk1("t8c_err", t_rsp_err, 1'b0);
        @(posedge clk); #1;
        t_rsp0_ready = 1'b1;
        @(posedge clk); #1;
        t_rsp0_ready = 1'b0;

        repeat (2) @(posedge clk);
        chkw("sb_drain", 64'(sb_q.size()), 64'h0);
        chkw("t8_drain", 64'(t_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
